// File: rtl/pkt_pkg.sv
// Shared ingress-framer types: FSM state encoding and LEN field width.
// The switch bench imports the same definitions.
package pkt_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        EMIT_DA,
        EMIT_LEN,
        EMIT_DATA
    } ingress_state_e;

    // States in which the framer owns the switch FIFO write port.
    function automatic logic is_emit_state(input ingress_state_e s);
        return (s == EMIT_DA) || (s == EMIT_LEN) || (s == EMIT_DATA);
    endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Single-packet payload buffer: synchronous write, asynchronous read.
// Intended to map onto distributed RAM.
module pkt_buf_ram
    import pkt_pkg::*;
#(
    parameter int DEPTH = 255,
    parameter int AW    = LEN_W,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pkt_ingress_framer.sv
// Ingress framer: buffers one host packet, then emits DA, LEN, payload to the
// switch FIFO, honouring fifo_full. Oversize packets are discarded.
module pkt_ingress_framer
    import pkt_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  data,
    output logic        data_status,
    input  logic        fifo_full,
    output logic        busy,
    output logic        drop_err,
    output logic [15:0] pkt_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    ingress_state_e   state;
    ingress_state_e   state_next;

    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic [LEN_W-1:0] len_reg;
    logic [7:0]       da_reg;
    logic [7:0]       buf_rd_data;

    logic accept;
    logic emit;
    logic buf_we;
    logic load_da;
    logic clear_len;
    logic load_len;
    logic wr_inc;
    logic rd_clr;
    logic rd_inc;
    logic pkt_done;

    // Reset gating keeps the host and the switch FIFO quiet while reset is held,
    // even though the state register only clears on the next edge.
    assign in_ready    = !reset && !is_emit_state(state);
    assign accept      = in_valid && in_ready;
    assign emit        = !reset && is_emit_state(state) && !fifo_full;
    assign data_status = emit;
    assign busy        = (state != IDLE);

    pkt_buf_ram #(
        .DEPTH (MAX_LEN),
        .AW    (LEN_W),
        .DW    (8)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (rd_cnt),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        buf_we     = 1'b0;
        load_da    = 1'b0;
        clear_len  = 1'b0;
        load_len   = 1'b0;
        wr_inc     = 1'b0;
        rd_clr     = 1'b0;
        rd_inc     = 1'b0;
        pkt_done   = 1'b0;
        drop_err   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    load_da = 1'b1;
                    if (in_last) begin
                        clear_len  = 1'b1;
                        state_next = EMIT_DA;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (wr_cnt < MAX_LEN_V) begin
                        buf_we = 1'b1;
                        wr_inc = 1'b1;
                        if (in_last) begin
                            load_len   = 1'b1;
                            state_next = EMIT_DA;
                        end
                    end else begin
                        // Buffer already full: this byte makes the packet oversize.
                        drop_err   = 1'b1;
                        state_next = in_last ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            EMIT_DA: begin
                if (emit) begin
                    state_next = EMIT_LEN;
                end
            end
            EMIT_LEN: begin
                if (emit) begin
                    if (len_reg == '0) begin
                        pkt_done   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rd_clr     = 1'b1;
                        state_next = EMIT_DATA;
                    end
                end
            end
            EMIT_DATA: begin
                if (emit) begin
                    rd_inc = 1'b1;
                    if (rd_cnt == (len_reg - ONE)) begin
                        pkt_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        data = 8'h00;
        case (state)
            EMIT_DA:   data = da_reg;
            EMIT_LEN:  data = len_reg;
            EMIT_DATA: data = buf_rd_data;
            default:   data = 8'h00;
        endcase
    end

    // Datapath registers; all hold whenever the FSM is stalled by fifo_full.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            len_reg   <= '0;
            da_reg    <= '0;
            pkt_count <= '0;
        end else begin
            if (load_da) begin
                da_reg <= in_data;
                wr_cnt <= '0;
            end else if (wr_inc) begin
                wr_cnt <= wr_cnt + ONE;
            end

            if (clear_len) begin
                len_reg <= '0;
            end else if (load_len) begin
                len_reg <= wr_cnt + ONE;
            end

            if (rd_clr) begin
                rd_cnt <= '0;
            end else if (rd_inc) begin
                rd_cnt <= rd_cnt + ONE;
            end

            if (pkt_done) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_ingress_framer.sv
// Self-checking bench for pkt_ingress_framer: directed and random packets are
// compared against an expected switch byte stream built from packet contents.
module tb_pkt_ingress_framer;

    localparam int MAX_LEN    = 255;
    localparam int WAIT_LIMIT = 5000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  data;
    logic        data_status;
    logic        fifo_full;
    logic        busy;
    logic        drop_err;
    logic [15:0] pkt_count;

    logic full_force;
    logic full_rand_en;
    logic rand_full;
    bit   gap_en;

    int n_checks       = 0;
    int n_fail         = 0;
    int cyc            = 0;
    int exp_pkts       = 0;
    int exp_drops      = 0;
    int drop_cnt       = 0;
    int full_write_cnt = 0;
    int stall_timeouts = 0;
    int obs_idx        = 0;

    logic [7:0] obs_q[$];
    int         obs_cyc[$];
    logic [7:0] exp_q[$];

    pkt_ingress_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .data        (data),
        .data_status (data_status),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .drop_err    (drop_err),
        .pkt_count   (pkt_count)
    );

    assign fifo_full = full_force | (full_rand_en & rand_full);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random switch-FIFO back-pressure, applied only when enabled.
    initial begin
        rand_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rand_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Record every byte written to the switch FIFO and every drop pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_status) begin
                obs_q.push_back(data);
                obs_cyc.push_back(cyc);
            end
            if (data_status && fifo_full) full_write_cnt++;
            if (drop_err) drop_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last, output int acc_cyc);
        int waited;
        waited = 0;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= WAIT_LIMIT) stall_timeouts++;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send DA plus len random payload bytes; optionally record the expected wire image.
    task automatic applyStimulus(input logic [7:0] da, input int len, input bit keep,
                                 output int first_acc, output int last_acc);
        logic [7:0] pl[$];
        int a;
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        sendByte(da, (len == 0), first_acc);
        last_acc = first_acc;
        for (int i = 0; i < len; i++) begin
            sendByte(pl[i], (i == len - 1), a);
            last_acc = a;
        end
        if (keep && len <= MAX_LEN) begin
            exp_q.push_back(da);
            exp_q.push_back(8'(len));
            for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
            exp_pkts++;
        end
        if (len > MAX_LEN) exp_drops++;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= WAIT_LIMIT) stall_timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic waitWrites(input int target);
        int waited;
        waited = 0;
        while (obs_q.size() < target && waited < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= WAIT_LIMIT) stall_timeouts++;
    endtask

    task automatic checkStream(input string tag);
        int n_obs;
        n_obs = obs_q.size() - obs_idx;
        checkOutput({tag, "_nbytes"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_obs; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), obs_q[obs_idx + i], exp_q[i]);
        obs_idx = obs_q.size();
        exp_q.delete();
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_in_ready_in_reset"}, in_ready, 1'b0);
        checkOutput({tag, "_ds_in_reset"}, data_status, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_pkts = 0;
        exp_q.delete();
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
        checkOutput({tag, "_pkt_count_after"}, pkt_count, 16'd0);
        checkOutput({tag, "_ds_after"}, data_status, 1'b0);
        @(posedge clk);
        #1;
        obs_idx = obs_q.size();
    endtask

    initial begin
        int a, b, f1, l1, f2, l2, base, last_acc;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_data      = 8'h00;
        full_force   = 1'b0;
        full_rand_en = 1'b0;
        gap_en       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1'b0);
        checkOutput("reset_data_status", data_status, 1'b0);
        checkOutput("reset_drop_err", drop_err, 1'b0);
        checkOutput("reset_pkt_count", pkt_count, 16'd0);
        checkOutput("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] Test 1: three-byte packet, no back-pressure");
        base = obs_q.size();
        sendByte(8'h55, 1'b0, a);
        sendByte(8'h01, 1'b0, a);
        sendByte(8'h02, 1'b0, a);
        sendByte(8'h03, 1'b1, last_acc);
        exp_q.push_back(8'h55); exp_q.push_back(8'h03);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_pkts++;
        waitIdle();
        if (obs_q.size() >= base + 5) begin
            checkOutput("t1_first_write_latency", obs_cyc[base], last_acc);
            checkOutput("t1_burst_span", obs_cyc[base + 4] - obs_cyc[base], 4);
        end
        checkStream("t1");
        checkOutput("t1_pkt_count", pkt_count, 16'(exp_pkts));

        $display("[TB] Test 2: zero-length packet");
        sendByte(8'hAA, 1'b1, a);
        exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
        exp_pkts++;
        waitIdle();
        checkStream("t2");
        @(negedge clk);
        checkOutput("t2_in_ready_idle", in_ready, 1'b1);
        checkOutput("t2_pkt_count", pkt_count, 16'(exp_pkts));
        @(posedge clk);
        #1;

        $display("[TB] Test 3: fifo_full stall on payload byte 1");
        base = obs_q.size();
        applyStimulus(8'($urandom), 4, 1'b1, a, b);
        waitWrites(base + 3);
        full_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_stall_ds%0d", i), data_status, 1'b0);
            @(posedge clk);
            #1;
        end
        full_force = 1'b0;
        waitIdle();
        checkStream("t3");

        $display("[TB] Test 4: oversize drop then maximum-length packet");
        applyStimulus(8'h3C, MAX_LEN + 1, 1'b1, a, b);
        waitIdle();
        checkOutput("t4_drop_cnt", drop_cnt, exp_drops);
        checkStream("t4_drop");
        checkOutput("t4_pkt_count_unchanged", pkt_count, 16'(exp_pkts));
        applyStimulus(8'hC3, MAX_LEN, 1'b1, a, b);
        waitIdle();
        checkStream("t4_max");
        checkOutput("t4_pkt_count", pkt_count, 16'(exp_pkts));

        $display("[TB] Test 5: second packet back-pressured behind the first");
        base = obs_q.size();
        applyStimulus(8'h11, 6, 1'b1, f1, l1);
        applyStimulus(8'h22, 3, 1'b1, f2, l2);
        waitIdle();
        if (obs_q.size() >= base + 8)
            checkOutput("t5_second_da_accept_cycle", f2, obs_cyc[base + 7] + 2);
        checkStream("t5");

        $display("[TB] Random packets with gaps and back-pressure");
        gap_en       = 1'b1;
        full_rand_en = 1'b1;
        for (int p = 0; p < 10; p++) begin
            applyStimulus(8'($urandom), (p == 5) ? MAX_LEN + 5 : int'($urandom_range(0, 24)), 1'b1, a, b);
        end
        waitIdle();
        checkStream("rand");
        checkOutput("rand_pkt_count", pkt_count, 16'(exp_pkts));
        checkOutput("rand_drop_cnt", drop_cnt, exp_drops);
        gap_en       = 1'b0;
        full_rand_en = 1'b0;

        $display("[TB] Test 6: reset mid-COLLECT and mid-EMIT_DATA");
        sendByte(8'h77, 1'b0, a);
        sendByte(8'h01, 1'b0, a);
        sendByte(8'h02, 1'b0, a);
        applyReset("t6_collect");
        base = obs_q.size();
        applyStimulus(8'h88, 10, 1'b0, a, b);
        waitWrites(base + 5);
        applyReset("t6_emit");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_no_writes_after_reset", obs_q.size() - obs_idx, 0);
        applyStimulus(8'h99, 2, 1'b1, a, b);
        waitIdle();
        checkStream("t6_after");
        checkOutput("t6_pkt_count", pkt_count, 16'(exp_pkts));

        checkOutput("never_write_when_full", full_write_cnt, 0);
        checkOutput("final_drop_cnt", drop_cnt, exp_drops);
        checkOutput("no_wait_timeouts", stall_timeouts, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
